// File: rtl/switchbox_pkg.sv
// Shared definitions for the 5x4 routing switch box configuration path.
// Holds the geometry (NTOP, NSIDE), the entry format width (FW), the frame
// sync byte, the side-code constants used in an entry's select field, the
// loader state enum and helpers mapping a frame entry slot to its own
// side/position.
package switchbox_pkg;

    localparam int NTOP     = 5;
    localparam int NSIDE    = 4;
    localparam int FW       = 6;
    localparam int NENT     = 2 * NTOP + 2 * NSIDE;
    localparam int PAY_BITS = NENT * FW;

    localparam logic [7:0] SYNC = 8'hA5;

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2,
        VERIFY  = 2'd3
    } state_t;

    // Frame slot order: top[0..4], bottom[0..4], left[0..3], right[0..3].
    function automatic logic [2:0] entry_side(input int k);
        if (k < NTOP)                    return SIDE_TOP;
        else if (k < 2 * NTOP)           return SIDE_BOTTOM;
        else if (k < 2 * NTOP + NSIDE)   return SIDE_LEFT;
        else                             return SIDE_RIGHT;
    endfunction

    function automatic logic [2:0] entry_pos(input int k);
        int p;
        if (k < NTOP)                    p = k;
        else if (k < 2 * NTOP)           p = k - NTOP;
        else if (k < 2 * NTOP + NSIDE)   p = k - 2 * NTOP;
        else                             p = k - 2 * NTOP - NSIDE;
        return 3'(p);
    endfunction

endpackage

// File: rtl/switchbox_cfg_loader_if.sv
// Serial configuration handshake between a bitstream source (master) and
// the switch box configuration loader (slave).
//   cfg_valid : source presents a bit
//   cfg_bit   : serial data bit
//   cfg_ready : loader accepts a bit this cycle
// A bit transfers on a rising clock edge where cfg_valid && cfg_ready.
interface switchbox_cfg_loader_if;

    logic cfg_valid;
    logic cfg_bit;
    logic cfg_ready;

    modport master (output cfg_valid, output cfg_bit, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_bit, output cfg_ready);

endinterface

// File: rtl/switchbox_entry_check.sv
// Combinational validity check of one routing entry.
//   entry    : [FW-1:3] source index, [2:0] source side code
//   own_side : side code of the wire this entry drives
//   own_pos  : position of that wire on its side
//   ok       : 1 when the entry selects an existing wire and is no self-loop
module switchbox_entry_check
    import switchbox_pkg::*;
(
    input  logic [FW-1:0] entry,
    input  logic [2:0]    own_side,
    input  logic [2:0]    own_pos,
    output logic          ok
);

    logic [2:0] sel;
    logic [2:0] idx;

    assign sel = entry[2:0];
    assign idx = entry[FW-1:3];

    always_comb begin
        ok = 1'b1;
        if (sel > SIDE_LEFT)
            ok = 1'b0;
        if ((sel == SIDE_TOP || sel == SIDE_BOTTOM) && idx >= 3'(NTOP))
            ok = 1'b0;
        if ((sel == SIDE_RIGHT || sel == SIDE_LEFT) && idx >= 3'(NSIDE))
            ok = 1'b0;
        // A wire may not be driven from itself.
        if (sel == own_side && idx == own_pos)
            ok = 1'b0;
    end

endmodule

// File: rtl/switchbox_cfg_loader.sv
// Serial configuration loader for the 5x4 routing switch box.
// Hunts for the sync byte, shifts 18 six-bit entries into a shadow
// register, receives an 8-bit checksum, then validates and commits the
// shadow to the active select outputs in a single edge.
//   clk, rst     : clock, asynchronous active-high reset
//   cfg          : serial bit handshake (slave side)
//   cfg_top/bottom/left/right : active entries, entry i at [i*FW +: FW]
//   busy         : frame in progress (state is not HUNT)
//   cfg_done     : one-cycle pulse, frame committed
//   cfg_err      : one-cycle pulse, frame rejected
module switchbox_cfg_loader
    import switchbox_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    switchbox_cfg_loader_if.slave cfg,
    output logic [NTOP*FW-1:0]    cfg_top,
    output logic [NTOP*FW-1:0]    cfg_bottom,
    output logic [NSIDE*FW-1:0]   cfg_left,
    output logic [NSIDE*FW-1:0]   cfg_right,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_err
);

    localparam logic [6:0] PCNT_LAST = 7'(PAY_BITS - 1);

    state_t              state;
    logic [7:0]          window;
    logic [PAY_BITS-1:0] shadow;
    logic [6:0]          pcnt;
    logic [2:0]          ccnt;
    logic [7:0]          csum_rx;

    logic [FW-1:0]       ent [NENT];
    logic [NENT-1:0]     ent_ok;
    logic [7:0]          csum_calc;
    logic                xfer;
    logic                frame_good;

    assign cfg.cfg_ready = (state != VERIFY);
    assign busy          = (state != HUNT);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

    // The first entry received ends up in the top bits of the shadow.
    always_comb begin
        for (int k = 0; k < NENT; k++)
            ent[k] = shadow[PAY_BITS-1-k*FW -: FW];
    end

    always_comb begin
        csum_calc = 8'd0;
        for (int k = 0; k < NENT; k++)
            csum_calc = csum_calc + {2'b00, ent[k]};
    end

    for (genvar k = 0; k < NENT; k++) begin : g_check
        switchbox_entry_check u_check (
            .entry    (ent[k]),
            .own_side (entry_side(k)),
            .own_pos  (entry_pos(k)),
            .ok       (ent_ok[k])
        );
    end

    assign frame_good = (&ent_ok) && (csum_calc == csum_rx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            window     <= '0;
            shadow     <= '0;
            pcnt       <= '0;
            ccnt       <= '0;
            csum_rx    <= '0;
            cfg_top    <= '0;
            cfg_bottom <= '0;
            cfg_left   <= '0;
            cfg_right  <= '0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                HUNT: begin
                    if (xfer) begin
                        // Window is cleared on sync so a later hunt starts fresh.
                        if ({window[6:0], cfg.cfg_bit} == SYNC) begin
                            window <= '0;
                            pcnt   <= '0;
                            state  <= PAYLOAD;
                        end else begin
                            window <= {window[6:0], cfg.cfg_bit};
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        shadow <= {shadow[PAY_BITS-2:0], cfg.cfg_bit};
                        if (pcnt == PCNT_LAST) begin
                            pcnt  <= '0;
                            ccnt  <= '0;
                            state <= CSUM;
                        end else begin
                            pcnt <= pcnt + 7'd1;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        csum_rx <= {csum_rx[6:0], cfg.cfg_bit};
                        if (ccnt == 3'd7) begin
                            ccnt  <= '0;
                            state <= VERIFY;
                        end else begin
                            ccnt <= ccnt + 3'd1;
                        end
                    end
                end
                VERIFY: begin
                    if (frame_good) begin
                        for (int i = 0; i < NTOP; i++) begin
                            cfg_top[i*FW +: FW]    <= ent[i];
                            cfg_bottom[i*FW +: FW] <= ent[NTOP+i];
                        end
                        for (int i = 0; i < NSIDE; i++) begin
                            cfg_left[i*FW +: FW]  <= ent[2*NTOP+i];
                            cfg_right[i*FW +: FW] <= ent[2*NTOP+NSIDE+i];
                        end
                        cfg_done <= 1'b1;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                    state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: doc/switchbox_cfg_loader.md
# switchbox_cfg_loader

Serial configuration loader for the 5×4 routing switch box. It receives a framed serial bitstream, assembles the 18 six-bit routing entries in a shadow register, and validates range, self-loop and checksum. On a good frame it commits the entries atomically to the parallel configuration outputs that drive the switch box's top, bottom, left and right select registers. It is the writer end of the switch box's configuration interface.

## Interface
- NTOP, 5, wires on top and bottom edges
- NSIDE, 4, wires on left and right edges
- FW, 6, entry width: [5:3] source index, [2:0] source side (0 = hi-Z, 1 = top, 2 = right, 3 = bottom, 4 = left)
- SYNC, 8'hA5, frame sync byte
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  serial bit valid
- cfg_bit  in  1  serial data bit
- cfg_ready  out  1  loader accepts a bit this cycle
- cfg_top  out  NTOP*FW  active top entries, entry i at [i*FW +: FW]
- cfg_bottom  out  NTOP*FW  active bottom entries
- cfg_left  out  NSIDE*FW  active left entries
- cfg_right  out  NSIDE*FW  active right entries
- busy  out  1  frame in progress (not HUNT)
- cfg_done  out  1  one-cycle pulse: frame committed
- cfg_err  out  1  one-cycle pulse: frame rejected

## Operation
- A bit transfers on a rising edge where cfg_valid && cfg_ready.
- Frame layout: SYNC (8 bits, MSB first), then 108 payload bits, then an 8-bit checksum (MSB first).
- Payload order: top[0..4], bottom[0..4], left[0..3], right[0..3]. Each entry is sent MSB first.
- Checksum: sum mod 256 of the 18 entries, each zero-extended to 8 bits.
- States:
  - HUNT: shift received bits into an 8-bit window. When the window including the current bit equals SYNC, go to PAYLOAD.
  - PAYLOAD: shift bits into the shadow entry, 7-bit counter 0..107. On the 108th bit, go to CSUM.
  - CSUM: 3-bit counter 0..7. On the 8th bit, go to VERIFY.
  - VERIFY: cfg_ready = 0. Evaluate the checks, then return to HUNT.
- Entry is invalid if any of these hold:
  - sel > 4;
  - sel ∈ {1,3} and index ≥ NTOP;
  - sel ∈ {2,4} and index ≥ NSIDE;
  - self-loop: the entry selects its own side and position, e.g. top[i] with sel = 1 and index = i.
- Frame good ⇔ all 18 entries are valid and the checksum matches. Good frame: copy the shadow to the active outputs and pulse cfg_done. Otherwise the active outputs are unchanged and cfg_err pulses.
- A SYNC pattern appearing inside the payload is ignored; resync happens only in HUNT.
- cfg_valid low stalls the counters; a frame has no timeout.

## Timing
- Reset: all cfg_* entry outputs = 0 (every switch wire hi-Z), state HUNT, shadow and counters cleared, cfg_ready = 1, busy = 0, cfg_done = cfg_err = 0.
- cfg_ready = 1 in every state except VERIFY.
- Last checksum bit accepted at edge N. VERIFY occupies cycle N→N+1. At edge N+1 the active outputs update and cfg_done or cfg_err rises for exactly one cycle.
- The first bit of the next frame can be accepted at edge N+2.
- Minimum frame = 124 accepted bits. Commit latency = 1 cycle after the last bit.
- Active outputs change only at a commit edge; they are never partially updated.
- Reset asserted mid-frame: the frame is discarded, outputs return to 0 asynchronously, and the loader restarts in HUNT.
- cfg_done and cfg_err are never high together.

## Structure
- Shared package switchbox_pkg holds:
  - NTOP, NSIDE, FW, SYNC;
  - the side-code constants SIDE_NONE/TOP/RIGHT/BOTTOM/LEFT;
  - the state enum HUNT/PAYLOAD/CSUM/VERIFY.
- One sub-module, switchbox_entry_check: combinational validity check of one entry, given the entry, its own side and its own position. It is instantiated 18 times.

## Test plan
- Frame with SYNC, 108 zero bits and checksum 8'h00 → cfg_done at last bit + 1; all outputs 0; cfg_err = 0.
- top[0] = 6'b001_010 (right[1]), all others 0, checksum 8'h0A → cfg_top[5:0] = 6'h0A after commit; other outputs unchanged.
- Same frame with checksum 8'h0B → cfg_err pulse; outputs keep their previous values.
- top[2] = 6'b101_011 (bottom[5], out of range) with a correct checksum → cfg_err. Separately, top[1] = 6'b001_001 (self-loop) → cfg_err.
- 37 leading garbage bits, then SYNC, then a valid frame, with cfg_valid toggling randomly → single cfg_done; counters stall correctly.
- Reset asserted at payload bit 50, then released and a full valid frame sent → outputs 0 after reset; the new frame commits normally.
